// File: rtl/seq_playback.sv
// seq_playback: walks the colour-sequence ROM from address 0 to L-1.
// Each step is shown on the LEDs for ON_CYCLES and then blanked for OFF_CYCLES.
// busy/done tell the game FSM when the playback has finished.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for start; level is sampled together with start
//   LOAD   | one cycle to let the ROM settle on the current address
//   SHOW   | pattern held on the LEDs, ON_CYCLES total
//   GAP    | LEDs blank, OFF_CYCLES total; then next step or finish
//   FIN    | one-cycle done pulse, address returns to 0
module seq_playback #(
    parameter int ON_CYCLES  = 25_000_000,
    parameter int OFF_CYCLES = 12_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [4:0] level,
    output logic [3:0] address,
    input  logic [3:0] pattern_in,
    output logic [3:0] leds,
    output logic       busy,
    output logic       done
);

    localparam int MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW         = $clog2(MAX_CYCLES) + 1;

    // Terminal counts; the timer stops at N-1 so it can never overflow.
    localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SHOW = 3'd2,
        S_GAP  = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [TW-1:0]   r_timer;
    logic [3:0]      r_addr;
    logic [3:0]      r_leds;
    logic [3:0]      r_last;
    logic [3:0]      w_last;
    logic            w_show_end;
    logic            w_gap_end;
    logic            w_last_step;
    logic            w_busy;
    logic            w_done;

    // Index of the final step; any level of 16 or more plays all 16 entries.
    assign w_last      = (level >= 5'd16) ? 4'd15 : (level[3:0] - 4'd1);
    assign w_show_end  = (r_timer == ON_LAST);
    assign w_gap_end   = (r_timer == OFF_LAST);
    assign w_last_step = (r_addr == r_last);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (level == 5'd0) ? S_FIN : S_LOAD;
                end
            end
            S_LOAD: w_next = S_SHOW;
            S_SHOW: begin
                if (w_show_end) begin
                    w_next = S_GAP;
                end
            end
            S_GAP: begin
                if (w_gap_end) begin
                    w_next = w_last_step ? S_FIN : S_LOAD;
                end
            end
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state register only.
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_LOAD, S_SHOW, S_GAP: w_busy = 1'b1;
            S_FIN:                 w_done = 1'b1;
            default: begin
                w_busy = 1'b0;
                w_done = 1'b0;
            end
        endcase
    end

    // Step timer: counts up to the terminal value of the current phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else begin
            case (r_state)
                S_SHOW:  r_timer <= w_show_end ? '0 : (r_timer + 1'b1);
                S_GAP:   r_timer <= w_gap_end  ? '0 : (r_timer + 1'b1);
                default: r_timer <= '0;
            endcase
        end
    end

    // Address, latched level and LED drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= 4'd0;
            r_leds <= 4'd0;
            r_last <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_leds <= 4'd0;
                    if (start && (level != 5'd0)) begin
                        r_addr <= 4'd0;
                        r_last <= w_last;
                    end
                end
                S_LOAD: begin
                    r_leds <= pattern_in;
                end
                S_SHOW: begin
                    if (w_show_end) begin
                        r_leds <= 4'd0;
                    end
                end
                S_GAP: begin
                    // The address stops at the last step, so it never wraps.
                    if (w_gap_end && !w_last_step) begin
                        r_addr <= r_addr + 4'd1;
                    end
                end
                S_FIN: begin
                    r_leds <= 4'd0;
                    r_addr <= 4'd0;
                end
                default: begin
                    r_leds <= 4'd0;
                    r_addr <= 4'd0;
                end
            endcase
        end
    end

    assign address = r_addr;
    assign leds    = r_leds;
    assign busy    = w_busy;
    assign done    = w_done;

endmodule

// File: tb/tb_seq_playback.sv
// Directed bench for seq_playback with short timing (ON=3, OFF=2).
module tb_seq_playback;

    localparam int ON  = 3;
    localparam int OFF = 2;
    localparam int PER = 1 + ON + OFF;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [4:0] level = 5'd0;
    logic [3:0] address;
    logic [3:0] pattern_in;
    logic [3:0] leds;
    logic       busy;
    logic       done;

    logic [3:0] rom [16] = '{4'h1, 4'h4, 4'h1, 4'h8, 4'h2, 4'h1, 4'h4, 4'h8,
                             4'h2, 4'h2, 4'h1, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4};

    int n_tests = 0;
    int n_fail  = 0;

    seq_playback #(.ON_CYCLES(ON), .OFF_CYCLES(OFF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .level      (level),
        .address    (address),
        .pattern_in (pattern_in),
        .leds       (leds),
        .busy       (busy),
        .done       (done)
    );

    assign pattern_in = rom[address];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    // Plays one sequence and checks every cycle from the start edge to one cycle past done.
    // eff is the hand-clamped level; restart_k injects a stray start, abort_k pulls reset.
    task automatic play(input int lvl, input int eff, input int restart_k, input int abort_k);
        int         total;
        int         step;
        int         ph;
        logic [3:0] e_leds;
        logic [3:0] e_addr;
        logic       e_busy;
        logic       e_done;
        total = eff * PER + 1;
        @(negedge clk);
        start = 1'b1;
        level = lvl[4:0];
        @(negedge clk);
        start = 1'b0;
        level = 5'd7;
        for (int k = 1; k <= total + 1; k++) begin
            step = (k - 1) / PER;
            ph   = (k - 1) % PER;
            if (k <= eff * PER) begin
                e_addr = 4'(step);
                e_leds = (ph >= 1 && ph <= ON) ? rom[step] : 4'h0;
                e_busy = 1'b1;
                e_done = 1'b0;
            end else if (k == total) begin
                e_addr = (eff > 0) ? 4'(eff - 1) : 4'h0;
                e_leds = 4'h0;
                e_busy = 1'b0;
                e_done = 1'b1;
            end else begin
                e_addr = 4'h0;
                e_leds = 4'h0;
                e_busy = 1'b0;
                e_done = 1'b0;
            end
            chk("leds",    k, {4'h0, leds},    {4'h0, e_leds});
            chk("address", k, {4'h0, address}, {4'h0, e_addr});
            chk("busy",    k, {7'h0, busy},    {7'h0, e_busy});
            chk("done",    k, {7'h0, done},    {7'h0, e_done});
            if (k == abort_k) begin
                #1 rst_n = 1'b0;
                #1;
                chk("rst_leds",    k, {4'h0, leds},    8'h00);
                chk("rst_busy",    k, {7'h0, busy},    8'h00);
                chk("rst_done",    k, {7'h0, done},    8'h00);
                chk("rst_address", k, {4'h0, address}, 8'h00);
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    chk("rst_hold_done", j, {7'h0, done}, 8'h00);
                    chk("rst_hold_leds", j, {4'h0, leds}, 8'h00);
                end
                rst_n = 1'b1;
                level = 5'd0;
                return;
            end
            if (k == restart_k) begin
                start = 1'b1;
                level = 5'd1;
            end else if (k == restart_k + 1) begin
                start = 1'b0;
                level = 5'd7;
            end
            @(negedge clk);
        end
        level = 5'd0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_leds",    0, {4'h0, leds},    8'h00);
        chk("reset_address", 0, {4'h0, address}, 8'h00);
        chk("reset_busy",    0, {7'h0, busy},    8'h00);
        chk("reset_done",    0, {7'h0, done},    8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        play(1,  1,  -1, -1);
        play(4,  4,  -1, -1);
        play(16, 16, -1, -1);
        play(20, 16, -1, -1);
        play(0,  0,  -1, -1);
        play(4,  4,   8, -1);
        play(4,  4,  -1, 14);
        play(2,  2,  -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
